rx_slicer_mer: RTL and testbench
================================

// Module: rx_slicer_mer
// PURPOSE
//  Receive-side counterpart of the time-shared pulse-shaping filter. Sits after the RX matched filter.
//  - Decimates sample-rate data (1s17) to symbol rate at a selectable sampling phase.
//  - Slices each symbol to a Gray-coded 4-ASK decision.
//  - Estimates the reference amplitude 'a' over fixed windows.
//  - Accumulates squared slicer error per window, for MER measurement.
// PARAMETERS
//  WIDTH     18     sample width, 1s17
//  SPS       4      samples per symbol; equals the TX time-share factor
//  LOG2_N    7      window length = 2^LOG2_N symbols
//  REF_INIT  32768  'a' used before the first window completes (0.25 in 1s17)
// PORTS
//  sys_clk      in   1            system clock; the only clock
//  reset_n      in   1            asynchronous, active-low reset
//  sam_clk_en   in   1            one-cycle sample strobe
//  x_in         in   WIDTH        matched-filter output, 1s17
//  phase_sel    in   2            sampling phase, 0..SPS-1
//  sym_out      out  2            decision: 00=-3a, 01=-a, 11=+a, 10=+3a
//  sym_valid    out  1            one-cycle pulse when sym_out updates
//  ref_level    out  WIDTH        current 'a' estimate, 1s17
//  err_acc      out  WIDTH+LOG2_N window sum of err^2, 1s17 per term
//  mer_valid    out  1            one-cycle pulse when err_acc and ref_level update
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - Outputs: sym_out=0, sym_valid=0, err_acc=0, mer_valid=0, ref_level=REF_INIT.
//    - Internals: phase counter=0, window counter=0, accumulators=0, state=ACQ.
//  - Phase counter: increments on sam_clk_en and wraps at SPS-1.
//    - Symbol strobe fires when counter==phase_sel on a sam_clk_en cycle.
//    - A phase_sel change takes effect at the next counter wrap. It does not restart the window.
//  - Pipeline, counted in sys_clk cycles after the strobe cycle:
//    - C1: register x_in.
//    - C2: sym_out/sym_valid, plus err = x - level(sym).
//    - C3: accumulate.
//  - Slicing thresholds are -2a, 0, +2a, all taken from ref_level.
//    - Tie rule: x >= threshold decides the upper level (x=0 -> 11; x=+2a -> 10).
//  - |x| saturates: -131072 maps to 131071.
//  - err^2 is a 2s34 product; bits [34:17] are accumulated.
//  - Accumulator widths are WIDTH+LOG2_N. No wrap is possible.
//  - FSM:
//    - ACQ: first window. Slices with REF_INIT. sym_valid is asserted; mer_valid is held 0.
//    - ACQ->TRK: at the end of the first window, with ref_level updated.
//    - TRK: at the end of every window:
//      - ref_level <= (sum|x| >>> LOG2_N) >>> 1
//      - err_acc <= window sum
//      - mer_valid pulses for 1 cycle, 1 cycle after the last C3
//      - both accumulators reload with the current term; no gap symbol
//  - A ref_level update applies from the first symbol of the next window.
//  - Simultaneous window end and strobe: the new symbol belongs to the next window.
//  - sam_clk_en gaps stall only the counters; the pipeline drains normally.
// CONFIGURATION
//  RX_SLICER_DC_EN defined:
//   - sum(x) is also accumulated per window.
//   - dc = sum >>> LOG2_N is subtracted from x (saturating) before slicing and before |x|, starting the next window.
//   - dc resets to 0.
//  RX_SLICER_DC_EN undefined: no DC logic; x is sliced directly.
// STRUCTURE
//  - Shared package gsm_pkg:
//    - Gray level codes (LVL_M3, LVL_M1, LVL_P1, LVL_P3)
//    - 1s17 format constants (MAX_POS=131071, MIN_NEG=-131072)
//    - FSM state encodings (ACQ, TRK)
//  - One sub-module, rx_win_accum: generic windowed accumulator with clear-and-load on window end.
//    - Instanced for |x|, err^2 and, under RX_SLICER_DC_EN, x.
// TESTING
//  1. a=32768, cycle levels -98304,-32768,32768,98304 at phase 0, SPS=4, LOG2_N=7.
//     -> sym_out 00,01,11,10; after window 2, ref_level=32768 and err_acc=0.
//  2. Only phase-2 samples nonzero (+98304), others 0, phase_sel=2.
//     -> all decisions 10; with phase_sel=0 -> all decisions 11 (x=0 tie).
//  3. x=+65536 with ref_level=32768 -> 10; x=+65535 -> 11; x=-65536 -> 01.
//  4. reset_n low mid-window (symbol 40).
//     -> outputs clear asynchronously, ref_level=REF_INIT; after release, mer_valid only after 2 full windows.
//  5. Constant x=-131072.
//     -> |x| saturates; ref_level=65535 after window 1; decisions 00; no accumulator overflow.
//  6. With RX_SLICER_DC_EN, signal of test 1 plus offset +4096.
//     -> window 2 err_acc within ±1 LSB per term of window-1 reference; decisions error-free.

Source files
------------

// File: rtl/gsm_pkg.sv
// rtl/gsm_pkg.sv - shared Gray level codes, 1s17 limits, RX FSM states and saturation helper
package gsm_pkg;

  // Gray-coded 4-ASK decisions: adjacent amplitudes differ in one bit
  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b11;
  localparam logic [1:0] LVL_P3 = 2'b10;

  // 1s17 full-scale limits
  localparam logic signed [17:0] MAX_POS = 18'sh1FFFF;
  localparam logic signed [17:0] MIN_NEG = 18'sh20000;

  typedef enum logic {
    ACQ = 1'b0,
    TRK = 1'b1
  } rx_state_e;

  // Clamp a two-bit-wider signed intermediate back into 1s17
  function automatic logic signed [17:0] sat_1s17(input logic signed [19:0] v);
    logic signed [19:0] hi;
    logic signed [19:0] lo;
    hi = 20'sh1FFFF;
    lo = -20'sh20000;
    if (v > hi) begin
      return MAX_POS;
    end else if (v < lo) begin
      return MIN_NEG;
    end
    return v[17:0];
  endfunction

endpackage

// File: rtl/rx_win_accum.sv
// rtl/rx_win_accum.sv - windowed accumulator that hands over its total and restarts on flush
module rx_win_accum #(
  parameter int AW = 25
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 add_i,
  input  logic                 flush_i,
  input  logic signed [AW-1:0] term_i,
  output logic signed [AW-1:0] sum_o
);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;

  // A flush starts the next window; a term arriving in that cycle is its first entry
  always_comb begin
    acc_d = acc_q;
    if (flush_i) begin
      acc_d = add_i ? term_i : '0;
    end else if (add_i) begin
      acc_d = acc_q + term_i;
    end
  end

  // Accumulator state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = acc_q;

endmodule

// File: rtl/rx_slicer_mer.sv
// rtl/rx_slicer_mer.sv - RX decimator, Gray 4-ASK slicer, amplitude and MER windows; RX_SLICER_DC_EN adds DC removal
module rx_slicer_mer
  import gsm_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int SPS      = 4,
  parameter int LOG2_N   = 7,
  parameter int REF_INIT = 32768
) (
  input  logic                           sys_clk,
  input  logic                           reset_n,
  input  logic                           sam_clk_en,
  input  logic signed [WIDTH-1:0]        x_in,
  input  logic        [1:0]              phase_sel,
  output logic        [1:0]              sym_out,
  output logic                           sym_valid,
  output logic signed [WIDTH-1:0]        ref_level,
  output logic        [WIDTH+LOG2_N-1:0] err_acc,
  output logic                           mer_valid
);

  localparam int         AW      = WIDTH + LOG2_N;
  localparam logic [1:0] LAST_PH = 2'(SPS - 1);

  logic [1:0]              cnt_q;
  logic [1:0]              phase_q;
  logic                    strobe;
  logic signed [WIDTH-1:0] x1_q;
  logic                    v1_q;
  logic [1:0]              sym_q;
  logic                    sym_valid_q;
  logic [WIDTH-1:0]        abs_q;
  logic [WIDTH-1:0]        sq_q;
  logic [LOG2_N-1:0]       win_q;
  logic                    done_q;
  rx_state_e               state_q;
  logic signed [WIDTH-1:0] ref_q;
  logic [AW-1:0]           err_acc_q;
  logic                    mer_valid_q;

  logic signed [WIDTH-1:0]   xc;
  logic signed [WIDTH+1:0]   xc_w, a_w, a2_w, a3_w, lvl_w, err_w, abs_w;
  logic [1:0]                sym_d;
  logic signed [WIDTH-1:0]   err_s, abs_s;
  logic signed [2*WIDTH-1:0] sq;
  logic signed [AW-1:0]      abs_term, sq_term, abs_sum, sq_sum, ref_full;
  logic                      unused_bits;

  assign strobe = sam_clk_en && (cnt_q == phase_q);

  // Sample-phase counter; a new phase selection is adopted only at the wrap
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (sam_clk_en) begin
      if (cnt_q == LAST_PH) begin
        cnt_q   <= '0;
        phase_q <= phase_sel;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

`ifdef RX_SLICER_DC_EN
  logic signed [WIDTH-1:0] dc_q;
  logic signed [WIDTH-1:0] x2_q;
  logic signed [WIDTH+1:0] xdc_w;
  logic signed [AW-1:0]    x_term, x_sum, dc_full;
  logic                    unused_dc_bits;

  assign xdc_w          = x1_q - dc_q;
  assign xc             = sat_1s17(xdc_w);
  assign x_term         = $signed({{LOG2_N{x2_q[WIDTH-1]}}, x2_q});
  assign dc_full        = x_sum >>> LOG2_N;
  assign unused_dc_bits = ^dc_full[AW-1:WIDTH];

  // Raw sample trails to C3 and the DC estimate refreshes at each window end
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      x2_q <= '0;
      dc_q <= '0;
    end else begin
      x2_q <= x1_q;
      if (done_q) begin
        dc_q <= dc_full[WIDTH-1:0];
      end
    end
  end

  rx_win_accum #(.AW(AW)) u_acc_x (
    .clk_i   (sys_clk),
    .rst_ni  (reset_n),
    .add_i   (sym_valid_q),
    .flush_i (done_q),
    .term_i  (x_term),
    .sum_o   (x_sum)
  );
`else
  assign xc = x1_q;
`endif

  assign xc_w  = xc;
  assign a_w   = ref_q;
  assign a2_w  = a_w <<< 1;
  assign a3_w  = a2_w + a_w;
  assign err_w = xc_w - lvl_w;
  assign err_s = sat_1s17(err_w);
  assign sq    = err_s * err_s;
  assign abs_w = xc_w[WIDTH+1] ? -xc_w : xc_w;
  assign abs_s = sat_1s17(abs_w);

  // Thresholds -2a, 0, +2a; a sample on a threshold takes the upper level
  always_comb begin
    sym_d = LVL_M3;
    lvl_w = -a3_w;
    if (xc_w >= a2_w) begin
      sym_d = LVL_P3;
      lvl_w = a3_w;
    end else if (!xc_w[WIDTH+1]) begin
      sym_d = LVL_P1;
      lvl_w = a_w;
    end else if (xc_w >= -a2_w) begin
      sym_d = LVL_M1;
      lvl_w = -a_w;
    end
  end

  // C1 captures the strobed sample; C2 registers decision, |x| and err^2 terms
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      x1_q        <= '0;
      v1_q        <= 1'b0;
      sym_q       <= LVL_M3;
      sym_valid_q <= 1'b0;
      abs_q       <= '0;
      sq_q        <= '0;
    end else begin
      v1_q        <= strobe;
      sym_valid_q <= v1_q;
      if (strobe) begin
        x1_q <= x_in;
      end
      if (v1_q) begin
        sym_q <= sym_d;
        abs_q <= abs_s;
        sq_q  <= sq[2*WIDTH-2:WIDTH-1];
      end
    end
  end

  // C3 counts window terms; done marks the cycle after the last term landed
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= sym_valid_q && (&win_q);
      if (sym_valid_q) begin
        win_q <= win_q + LOG2_N'(1);
      end
    end
  end

  assign abs_term = $signed({{LOG2_N{1'b0}}, abs_q});
  assign sq_term  = $signed({{LOG2_N{1'b0}}, sq_q});

  rx_win_accum #(.AW(AW)) u_acc_abs (
    .clk_i   (sys_clk),
    .rst_ni  (reset_n),
    .add_i   (sym_valid_q),
    .flush_i (done_q),
    .term_i  (abs_term),
    .sum_o   (abs_sum)
  );

  rx_win_accum #(.AW(AW)) u_acc_sq (
    .clk_i   (sys_clk),
    .rst_ni  (reset_n),
    .add_i   (sym_valid_q),
    .flush_i (done_q),
    .term_i  (sq_term),
    .sum_o   (sq_sum)
  );

  // 'a' is half the mean magnitude: mean |x| sits midway between a and 3a
  assign ref_full    = abs_sum >>> (LOG2_N + 1);
  assign unused_bits = ^{sq[2*WIDTH-1], sq[WIDTH-2:0], ref_full[AW-1:WIDTH]};

  // ACQ/TRK controller: first window only seeds 'a', later windows also report MER
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACQ;
      ref_q       <= WIDTH'(REF_INIT);
      err_acc_q   <= '0;
      mer_valid_q <= 1'b0;
    end else begin
      mer_valid_q <= 1'b0;
      if (done_q) begin
        ref_q <= ref_full[WIDTH-1:0];
        case (state_q)
          ACQ: state_q <= TRK;
          TRK: begin
            err_acc_q   <= sq_sum;
            mer_valid_q <= 1'b1;
          end
          default: state_q <= ACQ;
        endcase
      end
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign ref_level = ref_q;
  assign err_acc   = err_acc_q;
  assign mer_valid = mer_valid_q;

endmodule

// File: tb/tb_rx_slicer_mer.sv
// tb/tb_rx_slicer_mer.sv - randomized self-checking bench for rx_slicer_mer against a window-level model
module tb_rx_slicer_mer;

  localparam int WIDTH    = 18;
  localparam int SPS      = 4;
  localparam int LOG2_N   = 7;
  localparam int REF_INIT = 32768;
  localparam int N        = 1 << LOG2_N;

  logic                           sys_clk = 1'b0;
  logic                           reset_n = 1'b0;
  logic                           sam_clk_en = 1'b0;
  logic signed [WIDTH-1:0]        x_in = '0;
  logic        [1:0]              phase_sel = '0;
  logic        [1:0]              sym_out;
  logic                           sym_valid;
  logic signed [WIDTH-1:0]        ref_level;
  logic        [WIDTH+LOG2_N-1:0] err_acc;
  logic                           mer_valid;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: symbol phase, current 'a', DC, window sums
  int     ph_cnt, ph_eff, ref_m, dc_m, win_n;
  bit     acq_m;
  longint sum_abs, sum_sq, sum_x;
  int     exp_sym[$];
  longint exp_err[$];
  int     exp_ref[$];
  int     lv1[4] = '{-98304, -32768, 32768, 98304};
  int     t3[3]  = '{65536, 65535, -65536};
  int     ph;

  always #5 sys_clk = ~sys_clk;

  rx_slicer_mer #(
    .WIDTH(WIDTH), .SPS(SPS), .LOG2_N(LOG2_N), .REF_INIT(REF_INIT)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .sam_clk_en (sam_clk_en),
    .x_in       (x_in),
    .phase_sel  (phase_sel),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .ref_level  (ref_level),
    .err_acc    (err_acc),
    .mer_valid  (mer_valid)
  );

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat17(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  function automatic int rand_x();
    logic signed [17:0] r;
    r = 18'($urandom);
    return int'(r);
  endfunction

  function automatic void model_reset();
    ph_cnt = 0; ph_eff = 0; ref_m = REF_INIT; dc_m = 0; win_n = 0; acq_m = 1'b1;
    sum_abs = 0; sum_sq = 0; sum_x = 0;
    exp_sym.delete(); exp_err.delete(); exp_ref.delete();
  endfunction

  // One decided symbol: nearest Gray level, error energy, window bookkeeping
  function automatic void model_symbol(input int x);
    int xc, lvl, code, err, mag, new_ref;
    xc = sat17(longint'(x) - dc_m);
    if (xc >= 2 * ref_m) begin
      code = 2; lvl = 3 * ref_m;
    end else if (xc >= 0) begin
      code = 3; lvl = ref_m;
    end else if (xc >= -2 * ref_m) begin
      code = 1; lvl = -ref_m;
    end else begin
      code = 0; lvl = -3 * ref_m;
    end
    exp_sym.push_back(code);
    err = sat17(longint'(xc) - lvl);
    sum_sq += (longint'(err) * err) / 131072;
    mag = (xc < 0) ? -xc : xc;
    if (mag > 131071) mag = 131071;
    sum_abs += mag;
    sum_x   += x;
    win_n++;
    if (win_n == N) begin
      new_ref = int'((sum_abs / N) / 2);
      if (!acq_m) begin
        exp_err.push_back(sum_sq);
        exp_ref.push_back(new_ref);
      end
      acq_m = 1'b0;
      ref_m = new_ref;
`ifdef RX_SLICER_DC_EN
      dc_m = int'(sum_x >>> LOG2_N);
`endif
      sum_abs = 0; sum_sq = 0; sum_x = 0; win_n = 0;
    end
  endfunction

  task automatic step(input bit en, input int x, input logic [1:0] p);
    @(posedge sys_clk);
    #1;
    sam_clk_en = en;
    x_in       = x[WIDTH-1:0];
    phase_sel  = p;
    if (en) begin
      if (ph_cnt == ph_eff) model_symbol(x);
      if (ph_cnt == SPS - 1) begin
        ph_cnt = 0;
        ph_eff = int'(p);
      end else begin
        ph_cnt++;
      end
    end
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 0, phase_sel);
    check_eq("sym_drained", exp_sym.size(), 0);
    check_eq("mer_drained", exp_err.size(), 0);
    check_eq("ref_level", ref_level, ref_m);
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #2;
    reset_n    = 1'b0;
    sam_clk_en = 1'b0;
    x_in       = '0;
    #1;
    check_eq("rst_sym_out", sym_out, 0);
    check_eq("rst_sym_valid", sym_valid, 0);
    check_eq("rst_err_acc", err_acc, 0);
    check_eq("rst_mer_valid", mer_valid, 0);
    check_eq("rst_ref_level", ref_level, REF_INIT);
    model_reset();
    repeat (2) @(posedge sys_clk);
    #3 reset_n = 1'b1;
  endtask

  // Output monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (reset_n) begin
      if (sym_valid) begin
        check_eq("sym_pending", exp_sym.size() > 0, 1);
        if (exp_sym.size() > 0) check_eq("sym_out", sym_out, exp_sym.pop_front());
      end
      if (mer_valid) begin
        check_eq("mer_pending", exp_err.size() > 0, 1);
        if (exp_err.size() > 0) begin
          check_eq("err_acc", err_acc, exp_err.pop_front());
          check_eq("ref_at_mer", ref_level, exp_ref.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Four clean levels at phase 0, a = REF_INIT
    for (int i = 0; i < 3 * N * SPS; i++)
      step(1'b1, (ph_cnt == 0) ? lv1[(i / SPS) % 4] : rand_x(), 2'd0);
    drain();

    // Energy only on phase 2; then sample the zero phase
    for (int i = 0; i < 2 * N * SPS; i++)
      step(1'b1, (ph_cnt == 2) ? 98304 : 0, 2'd2);
    for (int i = 0; i < N * SPS; i++)
      step(1'b1, (ph_cnt == 2) ? 98304 : 0, 2'd0);
    drain();

    // Random samples, strobe gaps and phase changes
    ph = 0;
    for (int i = 0; i < 3 * N * SPS; i++) begin
      if (i % 64 == 0) ph = int'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 8, rand_x(), 2'(ph));
    end
    drain();

    // Reset at symbol 40 of a window
    for (int i = 0; i < 2000 && win_n != 40; i++) step(1'b1, rand_x(), 2'(ph));
    check_eq("reached_sym40", win_n, 40);
    do_reset();

    // Threshold ties with a = 32768, then a tracking window
    for (int i = 0; i < 2 * N * SPS; i++)
      step(1'b1, (ph_cnt == 1) ? t3[(i / SPS) % 3] : rand_x(), 2'd1);
    drain();

    // Negative full scale
    do_reset();
    for (int i = 0; i < 2 * N * SPS; i++) step(1'b1, -131072, 2'd0);
    drain();

`ifdef RX_SLICER_DC_EN
    // Offset levels, removed from the second window on
    do_reset();
    for (int i = 0; i < 2 * N * SPS; i++)
      step(1'b1, (ph_cnt == 0) ? lv1[(i / SPS) % 4] + 4096 : rand_x(), 2'd0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
